// File: rtl/ws_weight_feeder.sv
// Weight-stationary weight feeder.
// Streams DEPTH weights into each of NUM_PE processing elements in order,
// then issues read-valid / read-reset control words for a programmable number
// of compute passes, and finally pulses done for one cycle.
module ws_weight_feeder #(
    parameter int OP_WIDTH   = 8,
    parameter int CTRL_WIDTH = 9,
    parameter int NUM_PE     = 4,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            passes,
    input  logic                  src_valid,
    input  logic [OP_WIDTH-1:0]   src_data,
    output logic                  src_ready,
    output logic [NUM_PE-1:0]     wctrl,
    output logic [OP_WIDTH-1:0]   weight,
    output logic [CTRL_WIDTH-1:0] ctrl,
    output logic                  busy,
    output logic                  done
);

    localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PE_W  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(DEPTH - 1);
    localparam logic [PE_W-1:0]  LAST_PE   = PE_W'(NUM_PE - 1);

    // Control words seen by the PEs: bit0 read_valid; bits 3 and 7 read_reset.
    localparam logic [CTRL_WIDTH-1:0] CTRL_READ      = CTRL_WIDTH'(9'h001);
    localparam logic [CTRL_WIDTH-1:0] CTRL_READ_LAST = CTRL_WIDTH'(9'h089);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        COMPUTE = 2'd2,
        FIN     = 2'd3
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_word_cnt;
    logic [PE_W-1:0]       r_pe_cnt;
    logic [CNT_W-1:0]      r_rd_cnt;
    logic [7:0]            r_pass_cnt;
    logic [7:0]            r_passes;
    logic [NUM_PE-1:0]     r_wctrl;
    logic [OP_WIDTH-1:0]   r_weight;
    logic [CTRL_WIDTH-1:0] r_ctrl;
    logic                  r_busy;
    logic                  r_done;

    state_t                w_state_next;
    logic [CNT_W-1:0]      w_word_cnt_next;
    logic [PE_W-1:0]       w_pe_cnt_next;
    logic [CNT_W-1:0]      w_rd_cnt_next;
    logic [7:0]            w_pass_cnt_next;
    logic [7:0]            w_passes_next;
    logic [NUM_PE-1:0]     w_wctrl_next;
    logic [CTRL_WIDTH-1:0] w_ctrl_next;
    logic                  w_xfer;

    // src_ready is a pure state decode; a transfer needs it and src_valid.
    assign src_ready = (r_state == LOAD);
    assign w_xfer    = src_valid && (r_state == LOAD);

    assign wctrl  = r_wctrl;
    assign weight = r_weight;
    assign ctrl   = r_ctrl;
    assign busy   = r_busy;
    assign done   = r_done;

    // Next-state and counter update logic for the job sequencer.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        w_state_next    = r_state;
        w_word_cnt_next = r_word_cnt;
        w_pe_cnt_next   = r_pe_cnt;
        w_rd_cnt_next   = r_rd_cnt;
        w_pass_cnt_next = r_pass_cnt;
        w_passes_next   = r_passes;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_passes_next   = passes;
                    w_word_cnt_next = '0;
                    w_pe_cnt_next   = '0;
                    w_rd_cnt_next   = '0;
                    w_pass_cnt_next = '0;
                    w_state_next    = LOAD;
                end
            end
            LOAD: begin
                // Counters only move on a transfer, so a stall keeps position.
                if (w_xfer) begin
                    if (r_word_cnt == LAST_WORD) begin
                        w_word_cnt_next = '0;
                        if (r_pe_cnt == LAST_PE) begin
                            w_pe_cnt_next = '0;
                            w_state_next  = (r_passes == 8'd0) ? FIN : COMPUTE;
                        end else begin
                            w_pe_cnt_next = r_pe_cnt + PE_W'(1);
                        end
                    end else begin
                        w_word_cnt_next = r_word_cnt + CNT_W'(1);
                    end
                end
            end
            COMPUTE: begin
                if (r_rd_cnt == LAST_WORD) begin
                    w_rd_cnt_next   = '0;
                    w_pass_cnt_next = r_pass_cnt + 8'd1;
                    if (r_pass_cnt == r_passes - 8'd1) begin
                        w_state_next = FIN;
                    end
                end else begin
                    w_rd_cnt_next = r_rd_cnt + CNT_W'(1);
                end
            end
            FIN: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Output values for the next cycle, derived from next state/counters so
    // the registered outputs line up with the state they describe.
    always_comb begin
        w_wctrl_next = '0;
        for (int i = 0; i < NUM_PE; i++) begin
            w_wctrl_next[i] = w_xfer && (r_pe_cnt == PE_W'(i));
        end

        w_ctrl_next = '0;
        if (w_state_next == COMPUTE) begin
            w_ctrl_next = (w_rd_cnt_next == LAST_WORD) ? CTRL_READ_LAST : CTRL_READ;
        end
    end

    // State, counters and registered outputs; rst overrides everything,
    // including a transfer presented in the same cycle.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples values from before this edge, independent of statement order.
        if (rst) begin
            r_state    <= IDLE;
            r_word_cnt <= '0;
            r_pe_cnt   <= '0;
            r_rd_cnt   <= '0;
            r_pass_cnt <= '0;
            r_passes   <= '0;
            r_wctrl    <= '0;
            r_weight   <= '0;
            r_ctrl     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_word_cnt <= w_word_cnt_next;
            r_pe_cnt   <= w_pe_cnt_next;
            r_rd_cnt   <= w_rd_cnt_next;
            r_pass_cnt <= w_pass_cnt_next;
            r_passes   <= w_passes_next;
            r_wctrl    <= w_wctrl_next;
            if (w_xfer) begin
                r_weight <= src_data;
            end
            r_ctrl     <= w_ctrl_next;
            r_busy     <= (w_state_next != IDLE);
            r_done     <= (w_state_next == FIN);
        end
    end

endmodule
